// File: rtl/q1_pkg.sv
// q1_pkg: shared definitions for the q1 Moore FSM and the blocks that drive
// or model it.
//   - q1_state_t / ST_A..ST_E : 3-bit state codes of q1
//   - q1_in_t / IN_*          : 2-bit input codes applied to q1
//   - ctrl_t                  : stimulus-driver controller states
//   - q1_next()               : q1 next-state function (codes 5-7 map to A)
package q1_pkg;

    typedef logic [2:0] q1_state_t;

    localparam q1_state_t ST_A = 3'd0;
    localparam q1_state_t ST_B = 3'd1;
    localparam q1_state_t ST_C = 3'd2;
    localparam q1_state_t ST_D = 3'd3;
    localparam q1_state_t ST_E = 3'd4;

    typedef logic [1:0] q1_in_t;

    localparam q1_in_t IN_HOLD = 2'b00;
    localparam q1_in_t IN_01   = 2'b01;
    localparam q1_in_t IN_10   = 2'b10;
    localparam q1_in_t IN_11   = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        STEER = 1'b1
    } ctrl_t;

    function automatic q1_state_t q1_next(input q1_state_t state, input q1_in_t in_code);
        q1_state_t nxt;
        nxt = ST_A;
        case (state)
            ST_A: begin
                if (in_code == IN_10)      nxt = ST_D;
                else if (in_code == IN_01) nxt = ST_B;
                else                       nxt = ST_A;
            end
            ST_B: nxt = ST_A;
            ST_C: begin
                if (in_code == IN_11)      nxt = ST_B;
                else if (in_code == IN_01) nxt = ST_E;
                else                       nxt = ST_C;
            end
            ST_D: nxt = ST_C;
            ST_E: begin
                if (in_code == IN_11)      nxt = ST_D;
                else                       nxt = ST_E;
            end
            default: nxt = ST_A;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/q1_next_hop.sv
// q1_next_hop: combinational route table. Given the present q1 state and the
// wanted target, returns the input code for the next hop of the path.
//   shadow : present q1 state (input, 3 bits)
//   target : destination state (input, 3 bits)
//   hop    : q1 input code to apply this cycle (output, 2 bits)
// B and D advance on any input, so they always get IN_HOLD.
module q1_next_hop
    import q1_pkg::*;
(
    input  q1_state_t shadow,
    input  q1_state_t target,
    output q1_in_t    hop
);

    always_comb begin
        hop = IN_HOLD;
        case (shadow)
            ST_A: begin
                if (target == ST_A)      hop = IN_HOLD;
                else if (target == ST_B) hop = IN_01;
                else                     hop = IN_10;
            end
            ST_B: hop = IN_HOLD;
            ST_C: begin
                if (target == ST_C)      hop = IN_HOLD;
                else if (target == ST_E) hop = IN_01;
                else                     hop = IN_11;
            end
            ST_D: hop = IN_HOLD;
            ST_E: begin
                if (target == ST_E)      hop = IN_HOLD;
                else                     hop = IN_11;
            end
            default: hop = IN_HOLD;
        endcase
    end

endmodule

// File: rtl/q1_stim_driver.sv
// q1_stim_driver: accepts a target q1 state over valid/ready and drives the
// q1 input, cycle by cycle, along the route to that target. Keeps a shadow
// copy of q1's state and optionally cross-checks it against q1.
//   clk, reset   : clock, synchronous active-high reset
//   req_valid    : request present (in)
//   req_ready    : request can be accepted, high only in IDLE (out)
//   req_target   : requested target state code (in, 3 bits)
//   drv_in       : q1 input code (out, 2 bits)
//   shadow_state : registered model of q1's present state (out, 3 bits)
//   fsm_state    : q1's reported state, compared when CHECK_EN=1 (in, 3 bits)
//   busy         : controller is steering (out)
//   done         : one-cycle pulse, target reached (out)
//   err          : one-cycle pulse, illegal target rejected (out)
//   sync_err     : sticky, shadow and q1 disagreed at some cycle (out)
module q1_stim_driver
    import q1_pkg::*;
#(
    parameter bit CHECK_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_target,
    output logic [1:0] drv_in,
    output logic [2:0] shadow_state,
    input  logic [2:0] fsm_state,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       sync_err
);

    ctrl_t     ctrl;
    q1_state_t shadow;
    q1_state_t target_q;
    q1_in_t    hop;
    logic      arrived;

    q1_next_hop u_hop (
        .shadow (shadow),
        .target (target_q),
        .hop    (hop)
    );

    assign arrived      = (shadow == target_q);
    assign req_ready    = (ctrl == IDLE);
    assign busy         = (ctrl == STEER);
    assign shadow_state = shadow;

    // Hold the input at 00 whenever not actively moving toward the target.
    always_comb begin
        drv_in = IN_HOLD;
        if (ctrl == STEER && !arrived) drv_in = hop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl     <= IDLE;
            shadow   <= ST_A;
            target_q <= ST_A;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            // Shadow tracks q1 every cycle, including while idle.
            shadow <= q1_next(shadow, drv_in);
            done   <= 1'b0;
            err    <= 1'b0;
            case (ctrl)
                IDLE: begin
                    if (req_valid) begin
                        if (req_target <= ST_E) begin
                            target_q <= req_target;
                            ctrl     <= STEER;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                STEER: begin
                    // Arrival is judged on the shadow during this cycle, so
                    // for B and D the shadow has moved on by the time done shows.
                    if (arrived) begin
                        done <= 1'b1;
                        ctrl <= IDLE;
                    end
                end
                default: ctrl <= IDLE;
            endcase
        end
    end

    generate
        if (CHECK_EN) begin : g_check
            logic sync_err_q;
            always_ff @(posedge clk) begin
                if (reset)                       sync_err_q <= 1'b0;
                else if (fsm_state != shadow)    sync_err_q <= 1'b1;
            end
            assign sync_err = sync_err_q;
        end else begin : g_nocheck
            logic unused_fsm;
            assign unused_fsm = ^fsm_state;
            assign sync_err   = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_q1_stim_driver.sv
// Bench for q1_stim_driver: reference model built from the q1 transition
// rules and the route table, a table of request vectors, hand-written corner
// sequences and a randomized run.
module tb_q1_stim_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_target;
    logic [1:0] drv_in;
    logic [2:0] shadow_state;
    logic [2:0] fsm_state;
    logic       busy;
    logic       done;
    logic       err;
    logic       sync_err;

    always #5 clk = ~clk;

    q1_stim_driver #(.CHECK_EN(1'b1)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_target   (req_target),
        .drv_in       (drv_in),
        .shadow_state (shadow_state),
        .fsm_state    (fsm_state),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .sync_err     (sync_err)
    );

    int checks = 0;
    int errors = 0;

    // Route table [target][present state], states A..E.
    localparam logic [1:0] HOP [0:4][0:4] = '{
        '{2'b00, 2'b00, 2'b11, 2'b00, 2'b11},
        '{2'b01, 2'b00, 2'b11, 2'b00, 2'b11},
        '{2'b10, 2'b00, 2'b00, 2'b00, 2'b11},
        '{2'b10, 2'b00, 2'b11, 2'b00, 2'b11},
        '{2'b10, 2'b00, 2'b01, 2'b00, 2'b00}
    };

    // Reference model state
    logic [2:0] m_shadow, m_tq;
    bit         m_steer, m_done, m_err, m_sync;
    bit         track;

    function automatic logic [2:0] ref_next(input logic [2:0] s, input logic [1:0] i);
        case (s)
            3'd0:    return (i == 2'b10) ? 3'd3 : (i == 2'b01) ? 3'd1 : 3'd0;
            3'd1:    return 3'd0;
            3'd2:    return (i == 2'b11) ? 3'd1 : (i == 2'b01) ? 3'd4 : 3'd2;
            3'd3:    return 3'd2;
            3'd4:    return (i == 2'b11) ? 3'd3 : 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [1:0] m_drv();
        if (!m_steer || m_shadow == m_tq) return 2'b00;
        return HOP[m_tq][m_shadow];
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: check combinational outputs, advance model, check registers.
    task automatic cycle();
        logic [2:0] n_shadow, n_tq;
        bit n_steer, n_done, n_err, n_sync, arr, acc;
        logic [1:0] d;
        if (track) fsm_state = m_shadow;
        #1;
        chk("drv_in", drv_in, m_drv());
        chk("req_ready", req_ready, !m_steer);
        chk("busy", busy, m_steer);
        if (reset) begin
            n_shadow = 3'd0; n_tq = 3'd0; n_steer = 0;
            n_done = 0; n_err = 0; n_sync = 0;
        end else begin
            d        = m_drv();
            arr      = m_steer && (m_shadow == m_tq);
            acc      = !m_steer && req_valid && (req_target <= 3'd4);
            n_shadow = ref_next(m_shadow, d);
            n_done   = arr;
            n_err    = !m_steer && req_valid && (req_target > 3'd4);
            n_sync   = m_sync || (fsm_state != m_shadow);
            n_steer  = m_steer ? !arr : acc;
            n_tq     = acc ? req_target : m_tq;
        end
        @(posedge clk);
        #1;
        m_shadow = n_shadow; m_tq = n_tq; m_steer = n_steer;
        m_done = n_done; m_err = n_err; m_sync = n_sync;
        chk("shadow_state", shadow_state, m_shadow);
        chk("done", done, m_done);
        chk("err", err, m_err);
        chk("sync_err", sync_err, m_sync);
    endtask

    task automatic do_reset();
        reset = 1'b1; req_valid = 1'b0;
        cycle();
        reset = 1'b0;
    endtask

    task automatic wait_done(input string nm, output int n);
        n = 0;
        while (!done && n < 12) begin
            cycle();
            n++;
        end
        if (!done) chk({nm, "_timeout"}, 0, 1);
    endtask

    typedef struct {
        bit         pre_e;
        logic [2:0] tgt;
        int         edges;
        bit         exp_err;
        logic [2:0] fin;
    } vec_t;

    vec_t vt [15];

    initial begin
        int n;
        vt[0]  = '{1'b0, 3'd0, 1, 1'b0, 3'd0};
        vt[1]  = '{1'b0, 3'd1, 2, 1'b0, 3'd0};
        vt[2]  = '{1'b0, 3'd2, 3, 1'b0, 3'd2};
        vt[3]  = '{1'b0, 3'd3, 2, 1'b0, 3'd2};
        vt[4]  = '{1'b0, 3'd4, 4, 1'b0, 3'd4};
        vt[5]  = '{1'b0, 3'd5, 0, 1'b1, 3'd0};
        vt[6]  = '{1'b0, 3'd6, 0, 1'b1, 3'd0};
        vt[7]  = '{1'b0, 3'd7, 0, 1'b1, 3'd0};
        vt[8]  = '{1'b1, 3'd0, 5, 1'b0, 3'd0};
        vt[9]  = '{1'b1, 3'd1, 4, 1'b0, 3'd0};
        vt[10] = '{1'b1, 3'd2, 3, 1'b0, 3'd2};
        vt[11] = '{1'b1, 3'd3, 2, 1'b0, 3'd2};
        vt[12] = '{1'b1, 3'd4, 1, 1'b0, 3'd4};
        vt[13] = '{1'b1, 3'd6, 0, 1'b1, 3'd4};
        vt[14] = '{1'b0, 3'd2, 3, 1'b0, 3'd2};

        reset = 1'b1; req_valid = 1'b0; req_target = 3'd0; fsm_state = 3'd0;
        track = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        m_shadow = 3'd0; m_tq = 3'd0; m_steer = 0; m_done = 0; m_err = 0; m_sync = 0;
        chk("rst_shadow", shadow_state, 0);
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_drv", drv_in, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_sync", sync_err, 0);
        reset = 1'b0;

        // Table of single requests from A or from E
        for (int k = 0; k < 15; k++) begin
            do_reset();
            if (vt[k].pre_e) begin
                req_valid = 1'b1; req_target = 3'd4;
                cycle();
                req_valid = 1'b0;
                wait_done("pre_e", n);
            end
            req_valid = 1'b1; req_target = vt[k].tgt;
            cycle();
            req_valid = 1'b0;
            if (vt[k].exp_err) begin
                chk("vec_err", err, 1);
                chk("vec_idle", busy, 0);
                chk("vec_shadow_kept", shadow_state, vt[k].fin);
                cycle();
                chk("vec_err_pulse", err, 0);
            end else begin
                wait_done("vec", n);
                chk("vec_latency", n, vt[k].edges);
                chk("vec_final", shadow_state, vt[k].fin);
            end
        end

        // Reset in the middle of A->E, then C completes via 10,00
        do_reset();
        req_valid = 1'b1; req_target = 3'd4;
        cycle();
        req_valid = 1'b0;
        chk("mid_drv0", drv_in, 2);
        cycle();
        chk("mid_shadow_d", shadow_state, 3);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("mid_rst_shadow", shadow_state, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_drv", drv_in, 0);
        chk("mid_rst_done", done, 0);
        req_valid = 1'b1; req_target = 3'd2;
        cycle();
        req_valid = 1'b0;
        chk("c_drv0", drv_in, 2);
        cycle();
        chk("c_drv1", drv_in, 0);
        cycle();
        chk("c_shadow", shadow_state, 2);
        cycle();
        chk("c_done", done, 1);

        // sync_err: sticky until reset
        do_reset();
        track = 1'b0; fsm_state = 3'd2;
        cycle();
        chk("sync_set", sync_err, 1);
        track = 1'b1;
        req_valid = 1'b1; req_target = 3'd1;
        cycle();
        req_valid = 1'b0;
        wait_done("sync_req", n);
        chk("sync_sticky", sync_err, 1);
        do_reset();
        chk("sync_cleared", sync_err, 0);

        // Back-to-back: C then A accepted in C's done cycle
        req_valid = 1'b1; req_target = 3'd2;
        cycle();
        req_target = 3'd0;
        wait_done("b2b_first", n);
        chk("b2b_ready_at_done", req_ready, 1);
        cycle();
        req_valid = 1'b0;
        chk("b2b_busy", busy, 1);
        chk("b2b_drv0", drv_in, 3);
        cycle();
        chk("b2b_drv1", drv_in, 0);
        cycle();
        cycle();
        chk("b2b_done", done, 1);
        chk("b2b_final", shadow_state, 0);

        // Randomized run against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            reset      = ($urandom_range(0, 59) == 0);
            req_valid  = $urandom_range(0, 1);
            req_target = 3'($urandom_range(0, 7));
            track      = ($urandom_range(0, 49) != 0);
            if (!track) fsm_state = 3'($urandom_range(0, 7));
            cycle();
        end
        reset = 1'b0; req_valid = 1'b0; track = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
